// File: rtl/output_port_arbiter.sv
// Output-port arbiter: round-robin owner pick with wormhole lock from head to tail flit.
// Latency: 1 cycle request-to-grant; back-to-back hand-over on the tail edge; out_valid_o combinational.
// Backpressure: out_ready_i low stalls transfers and holds the lock. Optional watchdog: OUTPUT_ARB_TIMEOUT_EN.
module output_port_arbiter #(
    parameter int N_REQ       = 5,
    parameter int PTR_W       = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [N_REQ-1:0] req_tail_i,
    input  logic             out_ready_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             out_valid_o,
    output logic             locked_o,
    output logic             timeout_o
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    // Next pointer after an owner: wraps the last requester (or any out-of-range value) to 0.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
        return (idx >= LAST_IDX) ? '0 : idx + PTR_W'(1);
    endfunction

    // Round-robin search: first set bit at or above start, modulo N_REQ. Returns {found, index}.
    function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [PTR_W-1:0] start);
        logic [PTR_W-1:0] base;
        logic [PTR_W-1:0] idx;
        logic             found;
        int               pos;
        base  = (start > LAST_IDX) ? '0 : start;
        found = 1'b0;
        idx   = '0;
        // Walk downward so the closest candidate to the pointer is written last and wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = int'(base) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (|(req & (N_REQ'(1) << pos))) begin
                found = 1'b1;
                idx   = PTR_W'(pos);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [N_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

    state_t             state_q;
    logic [N_REQ-1:0]   grant_q;
    logic [PTR_W-1:0]   owner_q;
    logic [PTR_W-1:0]   ptr_q;

    logic               locked;
    logic               owner_vld;
    logic               tail_xfer;
    logic               wd_fire;
    logic               release_lock;
    logic [PTR_W-1:0]   ptr_after;
    logic [PTR_W:0]     idle_pick;
    logic [PTR_W:0]     rel_pick;

    assign locked    = (state_q == ST_LOCKED);
    // grant_q is one-hot on the owner, so masking avoids a variable bit-select.
    assign owner_vld = locked & (|(req_valid_i & grant_q));
    assign tail_xfer = owner_vld & out_ready_i & (|(req_tail_i & grant_q));

    assign release_lock = tail_xfer | wd_fire;
    assign ptr_after    = wrap_inc(owner_q);

    // Candidates while idle, and hand-over candidates at release (old owner excluded, so it ends up last).
    assign idle_pick = rr_pick(req_valid_i, ptr_q);
    assign rel_pick  = rr_pick(req_valid_i & ~grant_q, ptr_after);

`ifdef OUTPUT_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] stall_cnt;

    // Fires during the TIMEOUT_CYC-th consecutive cycle the owner has no valid flit.
    assign wd_fire = locked & ~owner_vld & (stall_cnt == CNT_LAST);

    // Stall counter: consecutive owner-idle locked cycles, cleared on owner activity and on any lock change.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            stall_cnt <= '0;
        end else if (!locked || owner_vld || release_lock) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign wd_fire            = 1'b0;
`endif

    // Arbitration FSM: pick in IDLE, hold through the packet, hand over or drop on tail/watchdog release.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (idle_pick[PTR_W]) begin
                        state_q <= ST_LOCKED;
                        owner_q <= idle_pick[PTR_W-1:0];
                        grant_q <= to_onehot(idle_pick[PTR_W-1:0]);
                    end else begin
                        grant_q <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (release_lock) begin
                        ptr_q <= ptr_after;
                        if (rel_pick[PTR_W]) begin
                            owner_q <= rel_pick[PTR_W-1:0];
                            grant_q <= to_onehot(rel_pick[PTR_W-1:0]);
                        end else begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign out_valid_o = owner_vld;
    assign locked_o    = locked;
    assign timeout_o   = wd_fire;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed scenarios plus randomized traffic against a reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Model tracks owner, pointer and stall count as plain integers.
module tb_output_port_arbiter;

    localparam int N  = 5;
    localparam int TO = 16;

    logic         clk;
    logic         arst;
    logic [N-1:0] req_valid_i;
    logic [N-1:0] req_tail_i;
    logic         out_ready_i;
    logic [N-1:0] grant_o;
    logic         out_valid_o;
    logic         locked_o;
    logic         timeout_o;

    int total;
    int bad;

    // Reference model state: owner (-1 when idle), round-robin pointer, stall count.
    int m_own;
    int m_ptr;
    int m_cnt;

    logic last_ov;
    logic last_to;

    output_port_arbiter #(
        .N_REQ      (N),
        .PTR_W      (3),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .req_valid_i(req_valid_i),
        .req_tail_i (req_tail_i),
        .out_ready_i(out_ready_i),
        .grant_o    (grant_o),
        .out_valid_o(out_valid_o),
        .locked_o   (locked_o),
        .timeout_o  (timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requester at or after 'from', cyclically; -1 if none.
    function automatic int rr_search(input logic [N-1:0] v, input int from);
        for (int k = 0; k < N; k++) begin
            if (v[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] g;
        g = '0;
        if (idx >= 0) g[idx] = 1'b1;
        return g;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance both.
    task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] t, input logic r);
        logic [N-1:0] eg;
        logic         ov;
        logic         to;
        int           n_own;
        int           n_ptr;
        int           n_cnt;
        req_valid_i = v;
        req_tail_i  = t;
        out_ready_i = r;
        #1;
        eg = onehot(m_own);
        ov = (m_own >= 0) && v[m_own];
        to = 1'b0;
`ifdef OUTPUT_ARB_TIMEOUT_EN
        to = (m_own >= 0) && !v[m_own] && (m_cnt == TO - 1);
`endif
        chk("grant", grant_o, eg);
        chk("locked", locked_o, (m_own >= 0));
        chk("out_valid", out_valid_o, ov);
        chk("timeout", timeout_o, to);
        last_ov = out_valid_o;
        last_to = timeout_o;
        n_own = m_own;
        n_ptr = m_ptr;
        n_cnt = m_cnt;
        if (m_own < 0) begin
            n_own = rr_search(v, m_ptr);
            n_cnt = 0;
        end else if ((ov && r && t[m_own]) || to) begin
            n_ptr = (m_own + 1) % N;
            n_own = rr_search(v & ~onehot(m_own), n_ptr);
            n_cnt = 0;
        end else begin
            n_cnt = ov ? 0 : m_cnt + 1;
        end
        @(posedge clk);
        m_own = n_own;
        m_ptr = n_ptr;
        m_cnt = n_cnt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        arst        = 1'b0;
        req_valid_i = '0;
        req_tail_i  = '0;
        out_ready_i = 1'b0;
        #1;
        chk("rst_grant", grant_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_timeout", timeout_o, 0);
        m_own = -1;
        m_ptr = 0;
        m_cnt = 0;
        @(negedge clk);
        arst = 1'b1;
    endtask

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] t;
        logic         r;
        total       = 0;
        bad         = 0;
        arst        = 1'b0;
        req_valid_i = '0;
        req_tail_i  = '0;
        out_ready_i = 1'b0;
        m_own       = -1;
        m_ptr       = 0;
        m_cnt       = 0;
        @(negedge clk);

        // 1: three-flit packet from requester 2, then pointer sits at 3.
        do_reset();
        cyc(5'b00100, 5'b00000, 1'b1);
        chk("t1_grant", grant_o, 5'b00100);
        cyc(5'b00100, 5'b00000, 1'b1);
        cyc(5'b00100, 5'b00000, 1'b1);
        cyc(5'b00100, 5'b00100, 1'b1);
        chk("t1_idle_grant", grant_o, 5'b00000);
        chk("t1_idle_locked", locked_o, 1'b0);
        cyc(5'b01010, 5'b00000, 1'b1);
        chk("t1_ptr3", grant_o, 5'b01000);

        // 2: all five request single-flit packets continuously.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cyc(5'b11111, 5'b11111, 1'b1);
            chk("t2_order", grant_o, onehot(k % N));
        end

        // 3: owner 1 mid-packet while requester 3 waits.
        do_reset();
        cyc(5'b00010, 5'b00000, 1'b1);
        cyc(5'b00010, 5'b00000, 1'b1);
        cyc(5'b01010, 5'b00000, 1'b1);
        chk("t3_hold", grant_o, 5'b00010);
        cyc(5'b01010, 5'b00010, 1'b1);
        chk("t3_handover", grant_o, 5'b01000);
        cyc(5'b01000, 5'b01000, 1'b1);

        // 4: tail held off by out_ready_i low for 4 cycles.
        cyc(5'b01000, 5'b00000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(5'b01000, 5'b01000, 1'b0);
            chk("t4_valid", last_ov, 1'b1);
            chk("t4_grant", grant_o, 5'b01000);
        end
        cyc(5'b01000, 5'b01000, 1'b1);
        chk("t4_release", grant_o, 5'b00000);

        // 5: asynchronous reset mid-packet from owner 4.
        do_reset();
        cyc(5'b10000, 5'b00000, 1'b1);
        cyc(5'b10000, 5'b00000, 1'b1);
        chk("t5_pre", grant_o, 5'b10000);
        #2;
        arst = 1'b0;
        #1;
        chk("t5_grant", grant_o, 5'b00000);
        chk("t5_locked", locked_o, 1'b0);
        chk("t5_valid", out_valid_o, 1'b0);
        m_own = -1;
        m_ptr = 0;
        m_cnt = 0;
        @(negedge clk);
        arst = 1'b1;
        cyc(5'b10001, 5'b00000, 1'b1);
        chk("t5_winner", grant_o, 5'b00001);

        // 6: owner 2 goes silent after its head flit while requester 0 waits.
        do_reset();
        cyc(5'b00100, 5'b00000, 1'b1);
        cyc(5'b00100, 5'b00000, 1'b1);
`ifdef OUTPUT_ARB_TIMEOUT_EN
        for (int k = 0; k < TO - 1; k++) begin
            cyc(5'b00001, 5'b00000, 1'b1);
        end
        chk("t6_no_early_timeout", last_to, 1'b0);
        chk("t6_still_held", grant_o, 5'b00100);
        cyc(5'b00001, 5'b00000, 1'b1);
        chk("t6_timeout_pulse", last_to, 1'b1);
        chk("t6_passed", grant_o, 5'b00001);
`else
        for (int k = 0; k < 100; k++) begin
            cyc(5'b00001, 5'b00000, 1'b1);
        end
        chk("t6_held_grant", grant_o, 5'b00100);
        chk("t6_held_locked", locked_o, 1'b1);
`endif

        // Randomized traffic with occasional resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            v = 5'($urandom) | 5'($urandom);
            t = 5'($urandom) & 5'($urandom);
            r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) v = '0;
            cyc(v, t, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
